// File: rtl/mpc_grid_ctrl_pkg.sv
// Shared types and helpers for the pad multiplexer: FSM states, select-width helper,
// and the bit positions of each edge's select inside the packed config word.
package mpc_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_BLANK  = 2'd1,
        ST_COMMIT = 2'd2
    } mpc_state_e;

    // Config word is {north_sel, east_sel, west_sel}; these index the SW-wide fields.
    localparam int EDGE_WEST  = 0;
    localparam int EDGE_EAST  = 1;
    localparam int EDGE_NORTH = 2;
    localparam int NUM_EDGES  = 3;

    function automatic int sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mpc_grid_ctrl_edge_mux.sv
// One pad edge: picks macro sel_i's o/oe slice out of N packed W-bit buses.
// A select with no matching macro, or an asserted blank, yields all zeros.
module mpc_edge_mux #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int SW = 2
) (
    input  logic [SW-1:0]  sel_i,
    input  logic           blank_i,
    input  logic [N*W-1:0] o_i,
    input  logic [N*W-1:0] oe_i,
    output logic [W-1:0]   o_o,
    output logic [W-1:0]   oe_o
);

    always_comb begin
        o_o  = '0;
        oe_o = '0;
        if (!blank_i) begin
            for (int i = 0; i < N; i++) begin
                if (sel_i == SW'(i)) begin
                    o_o  = o_i[i*W +: W];
                    oe_o = oe_i[i*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/mpc_grid_ctrl.sv
// Pad multiplexer for an NH x NV macro grid with handshaked, guard-blanked reconfiguration.
// Optional auto-scan through all macros is enabled with `define MPC_AUTO_SCAN_EN.
module mpc_grid_ctrl
    import mpc_pkg::*;
#(
    parameter int NH           = 2,
    parameter int NV           = 2,
    parameter int NW           = 10,
    parameter int WW           = 14,
    parameter int EW           = 14,
    parameter int GUARD_CYCLES = 4,
`ifdef MPC_AUTO_SCAN_EN
    parameter int DWELL_CYCLES = 1024,
`endif
    localparam int NM = NH * NV,
    localparam int SW = sel_w(NH * NV)
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef MPC_AUTO_SCAN_EN
    input  logic              scan_en_i,
`endif
    input  logic [3*SW-1:0]   cfg_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [NM*NW-1:0]  north_o_i,
    input  logic [NM*NW-1:0]  north_oe_i,
    input  logic [NM*WW-1:0]  west_o_i,
    input  logic [NM*WW-1:0]  west_oe_i,
    input  logic [NM*EW-1:0]  east_o_i,
    input  logic [NM*EW-1:0]  east_oe_i,
    output logic [NW-1:0]     io_north_o,
    output logic [NW-1:0]     io_north_oe,
    output logic [WW-1:0]     io_west_o,
    output logic [WW-1:0]     io_west_oe,
    output logic [EW-1:0]     io_east_o,
    output logic [EW-1:0]     io_east_oe,
    output logic [3*SW-1:0]   active_cfg_o,
    output logic              cfg_err_o
);

    localparam int               CNT_W      = $clog2(GUARD_CYCLES) + 1;
    localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

    mpc_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3*SW-1:0]   pend_q, pend_d;
    logic [3*SW-1:0]   active_q, active_d;
    logic              err_q, err_d;
    logic              blank;
    logic              pend_bad;

    logic [NW-1:0]     north_o_mux, north_oe_mux, north_o_q, north_oe_q;
    logic [WW-1:0]     west_o_mux, west_oe_mux, west_o_q, west_oe_q;
    logic [EW-1:0]     east_o_mux, east_oe_mux, east_o_q, east_oe_q;

`ifdef MPC_AUTO_SCAN_EN
    localparam int               DWELL_W    = $clog2(DWELL_CYCLES) + 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [3*SW-1:0]    scan_cfg;

    // Every edge steps to the next macro; the last (or an invalid) index wraps to 0.
    always_comb begin
        scan_cfg = '0;
        for (int e = 0; e < NUM_EDGES; e++) begin
            if ({1'b0, active_q[e*SW +: SW]} < (SW+1)'(NM - 1))
                scan_cfg[e*SW +: SW] = active_q[e*SW +: SW] + 1'b1;
        end
    end
`endif

    always_comb begin
        pend_bad = 1'b0;
        for (int e = 0; e < NUM_EDGES; e++) begin
            if ({1'b0, pend_q[e*SW +: SW]} >= (SW+1)'(NM))
                pend_bad = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        active_d    = active_q;
        err_d       = err_q;
        cfg_ready_o = 1'b0;
        blank       = 1'b1;
`ifdef MPC_AUTO_SCAN_EN
        dwell_d     = '0;
`endif
        case (state_q)
            ST_ACTIVE: begin
                cfg_ready_o = 1'b1;
                blank       = 1'b0;
                if (cfg_valid_i) begin
                    pend_d  = cfg_i;
                    cnt_d   = GUARD_LOAD;
                    state_d = ST_BLANK;
                end
`ifdef MPC_AUTO_SCAN_EN
                else if (scan_en_i) begin
                    if (dwell_q == DWELL_LAST) begin
                        pend_d  = scan_cfg;
                        cnt_d   = GUARD_LOAD;
                        state_d = ST_BLANK;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
`endif
            end
            ST_BLANK: begin
                if (cnt_q == '0) state_d = ST_COMMIT;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ST_COMMIT: begin
                active_d = pend_q;
                err_d    = err_q | pend_bad;
                state_d  = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACTIVE;
            cnt_q    <= '0;
            pend_q   <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

`ifdef MPC_AUTO_SCAN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dwell_q <= '0;
        else        dwell_q <= dwell_d;
    end
`endif

    mpc_edge_mux #(.N(NM), .W(NW), .SW(SW)) u_mux_north (
        .sel_i   (active_q[EDGE_NORTH*SW +: SW]),
        .blank_i (blank),
        .o_i     (north_o_i),
        .oe_i    (north_oe_i),
        .o_o     (north_o_mux),
        .oe_o    (north_oe_mux)
    );

    mpc_edge_mux #(.N(NM), .W(WW), .SW(SW)) u_mux_west (
        .sel_i   (active_q[EDGE_WEST*SW +: SW]),
        .blank_i (blank),
        .o_i     (west_o_i),
        .oe_i    (west_oe_i),
        .o_o     (west_o_mux),
        .oe_o    (west_oe_mux)
    );

    mpc_edge_mux #(.N(NM), .W(EW), .SW(SW)) u_mux_east (
        .sel_i   (active_q[EDGE_EAST*SW +: SW]),
        .blank_i (blank),
        .o_i     (east_o_i),
        .oe_i    (east_oe_i),
        .o_o     (east_o_mux),
        .oe_o    (east_oe_mux)
    );

    // Pads only ever see a registered copy, so a blank state reaches them one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            north_o_q  <= '0;
            north_oe_q <= '0;
            west_o_q   <= '0;
            west_oe_q  <= '0;
            east_o_q   <= '0;
            east_oe_q  <= '0;
        end else begin
            north_o_q  <= north_o_mux;
            north_oe_q <= north_oe_mux;
            west_o_q   <= west_o_mux;
            west_oe_q  <= west_oe_mux;
            east_o_q   <= east_o_mux;
            east_oe_q  <= east_oe_mux;
        end
    end

    assign io_north_o   = north_o_q;
    assign io_north_oe  = north_oe_q;
    assign io_west_o    = west_o_q;
    assign io_west_oe   = west_oe_q;
    assign io_east_o    = east_o_q;
    assign io_east_oe   = east_oe_q;
    assign active_cfg_o = active_q;
    assign cfg_err_o    = err_q;

endmodule

// File: tb/tb_mpc_grid_ctrl.sv
// Bench for mpc_grid_ctrl on a 3x2 grid (selects 6 and 7 are out of range).
// Reference model tracks handshake edges and derives blank/commit windows by arithmetic.
module tb_mpc_grid_ctrl;

    localparam int NH = 3, NV = 2, NM = 6, SW = 3;
    localparam int NW = 10, WW = 14, EW = 14, G = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              scan_en = 1'b0;
    logic [3*SW-1:0]   cfg_i = '0;
    logic              cfg_valid_i = 1'b0;
    logic              cfg_ready_o;
    logic [NM*NW-1:0]  north_o_i = '0, north_oe_i = '0;
    logic [NM*WW-1:0]  west_o_i = '0, west_oe_i = '0;
    logic [NM*EW-1:0]  east_o_i = '0, east_oe_i = '0;
    logic [NW-1:0]     io_north_o, io_north_oe;
    logic [WW-1:0]     io_west_o, io_west_oe;
    logic [EW-1:0]     io_east_o, io_east_oe;
    logic [3*SW-1:0]   active_cfg_o;
    logic              cfg_err_o;

    always #5 clk = ~clk;

    mpc_grid_ctrl #(
        .NH(NH), .NV(NV), .NW(NW), .WW(WW), .EW(EW),
`ifdef MPC_AUTO_SCAN_EN
        .DWELL_CYCLES(8),
`endif
        .GUARD_CYCLES(G)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef MPC_AUTO_SCAN_EN
        .scan_en_i    (scan_en),
`endif
        .cfg_i        (cfg_i),
        .cfg_valid_i  (cfg_valid_i),
        .cfg_ready_o  (cfg_ready_o),
        .north_o_i    (north_o_i),
        .north_oe_i   (north_oe_i),
        .west_o_i     (west_o_i),
        .west_oe_i    (west_oe_i),
        .east_o_i     (east_o_i),
        .east_oe_i    (east_oe_i),
        .io_north_o   (io_north_o),
        .io_north_oe  (io_north_oe),
        .io_west_o    (io_west_o),
        .io_west_oe   (io_west_oe),
        .io_east_o    (io_east_o),
        .io_east_oe   (io_east_oe),
        .active_cfg_o (active_cfg_o),
        .cfg_err_o    (cfg_err_o)
    );

    int n_cmp = 0, n_bad = 0;

    // Model: last edge index, edge of the last accepted handshake, committed/pending cfg.
    int              ecnt, acc;
    logic [3*SW-1:0] m_cfg, m_pend;
    bit              m_err;

    typedef struct {
        logic [3*SW-1:0] cfg;
        logic [NW-1:0]   n_o, n_oe;
        logic [WW-1:0]   w_o, w_oe;
        logic [EW-1:0]   e_o, e_oe;
        bit              err;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sel_of(input logic [3*SW-1:0] c, input int e);
        return int'(c[e*SW +: SW]);
    endfunction

    function automatic bit cfg_bad(input logic [3*SW-1:0] c);
        return sel_of(c, 0) >= NM || sel_of(c, 1) >= NM || sel_of(c, 2) >= NM;
    endfunction

    task automatic model_reset();
        ecnt  = 0;
        acc   = -100;
        m_cfg = '0;
        m_pend = '0;
        m_err = 1'b0;
    endtask

    // One clock: check ready, predict pads for the coming edge, advance model, compare.
    task automatic cycle(output bit hs);
        bit busy, blank;
        int e, s;
        logic [3*SW-1:0] cf;
        logic [NW-1:0] xno, xnoe;
        logic [WW-1:0] xwo, xwoe;
        logic [EW-1:0] xeo, xeoe;
        busy  = (acc <= ecnt) && (ecnt <= acc + G);
        chk("ready", {31'd0, cfg_ready_o}, {31'd0, !busy});
        e     = ecnt + 1;
        blank = (acc < e) && (e <= acc + G + 1);
        xno = '0; xnoe = '0; xwo = '0; xwoe = '0; xeo = '0; xeoe = '0;
        if (!blank) begin
            s = sel_of(m_cfg, 2);
            if (s < NM) begin xno = north_o_i[s*NW +: NW]; xnoe = north_oe_i[s*NW +: NW]; end
            s = sel_of(m_cfg, 0);
            if (s < NM) begin xwo = west_o_i[s*WW +: WW]; xwoe = west_oe_i[s*WW +: WW]; end
            s = sel_of(m_cfg, 1);
            if (s < NM) begin xeo = east_o_i[s*EW +: EW]; xeoe = east_oe_i[s*EW +: EW]; end
        end
        hs = cfg_valid_i && !busy;
        cf = cfg_i;
        @(posedge clk);
        ecnt = e;
        if (e == acc + G + 1) begin
            m_cfg = m_pend;
            if (cfg_bad(m_pend)) m_err = 1'b1;
        end
        if (hs) begin
            acc    = e;
            m_pend = cf;
        end
        @(negedge clk);
        chk("north_o",  32'(io_north_o),  32'(xno));
        chk("north_oe", 32'(io_north_oe), 32'(xnoe));
        chk("west_o",   32'(io_west_o),   32'(xwo));
        chk("west_oe",  32'(io_west_oe),  32'(xwoe));
        chk("east_o",   32'(io_east_o),   32'(xeo));
        chk("east_oe",  32'(io_east_oe),  32'(xeoe));
        chk("active_cfg", 32'(active_cfg_o), 32'(m_cfg));
        chk("cfg_err", {31'd0, cfg_err_o}, {31'd0, m_err});
    endtask

    // Asserts reset at a negedge, checks the asynchronous clear, releases at the next negedge.
    task automatic do_reset(input string nm);
        rst_n = 1'b0;
        #1;
        chk({nm, "_pads_o"},  32'({io_north_o, io_west_o, io_east_o}), 32'd0);
        chk({nm, "_pads_oe"}, 32'({io_north_oe, io_west_oe, io_east_oe}), 32'd0);
        chk({nm, "_active"},  32'(active_cfg_o), 32'd0);
        chk({nm, "_err"},     {31'd0, cfg_err_o}, 32'd0);
        chk({nm, "_ready"},   {31'd0, cfg_ready_o}, 32'd1);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_fixed_data();
        for (int m = 0; m < NM; m++) begin
            north_o_i[m*NW +: NW]  = NW'(10'h2C0 + m);
            north_oe_i[m*NW +: NW] = NW'(10'h3FF - m);
            west_o_i[m*WW +: WW]   = WW'(14'h1234 + m);
            west_oe_i[m*WW +: WW]  = WW'(14'h3FFF - m);
            east_o_i[m*EW +: EW]   = EW'(14'h0A50 + m);
            east_oe_i[m*EW +: EW]  = EW'(14'h3FFF - m);
        end
    endtask

    initial begin
        bit hs, got;
        int nblank;
        logic [3*SW-1:0] ca, cb, prev;

        tbl[0] = '{{3'd1, 3'd2, 3'd3}, 10'h2C1, 10'h3FE, 14'h1237, 14'h3FFC, 14'h0A52, 14'h3FFD, 1'b0};
        tbl[1] = '{{3'd5, 3'd0, 3'd4}, 10'h2C5, 10'h3FA, 14'h1238, 14'h3FFB, 14'h0A50, 14'h3FFF, 1'b0};
        tbl[2] = '{{3'd0, 3'd5, 3'd6}, 10'h2C0, 10'h3FF, 14'h0000, 14'h0000, 14'h0A55, 14'h3FFA, 1'b1};
        tbl[3] = '{{3'd3, 3'd7, 3'd1}, 10'h2C3, 10'h3FC, 14'h1235, 14'h3FFE, 14'h0000, 14'h0000, 1'b1};
        tbl[4] = '{{3'd2, 3'd2, 3'd2}, 10'h2C2, 10'h3FD, 14'h1236, 14'h3FFD, 14'h0A52, 14'h3FFD, 1'b1};

        set_fixed_data();
        model_reset();
        repeat (2) @(negedge clk);
        do_reset("rst0");
        cycle(hs);
        chk("rst_west_o",  32'(io_west_o),  32'h1234);
        chk("rst_west_oe", 32'(io_west_oe), 32'h3FFF);

        // Table: each config goes through handshake, G+1 blank edges, then the new routing.
        for (int i = 0; i < 5; i++) begin
            cfg_i = tbl[i].cfg;
            cfg_valid_i = 1'b1;
            cycle(hs);
            cfg_valid_i = 1'b0;
            nblank = 0;
            for (int k = 0; k < G + 1; k++) begin
                cycle(hs);
                if ({io_north_oe, io_west_oe, io_east_oe} == '0 &&
                    {io_north_o, io_west_o, io_east_o} == '0) nblank++;
            end
            chk($sformatf("tbl%0d_blank_cycles", i), 32'(nblank), 32'(G + 1));
            cycle(hs);
            chk($sformatf("tbl%0d_n_o", i),  32'(io_north_o),  32'(tbl[i].n_o));
            chk($sformatf("tbl%0d_n_oe", i), 32'(io_north_oe), 32'(tbl[i].n_oe));
            chk($sformatf("tbl%0d_w_o", i),  32'(io_west_o),   32'(tbl[i].w_o));
            chk($sformatf("tbl%0d_w_oe", i), 32'(io_west_oe),  32'(tbl[i].w_oe));
            chk($sformatf("tbl%0d_e_o", i),  32'(io_east_o),   32'(tbl[i].e_o));
            chk($sformatf("tbl%0d_e_oe", i), 32'(io_east_oe),  32'(tbl[i].e_oe));
            chk($sformatf("tbl%0d_active", i), 32'(active_cfg_o), 32'(tbl[i].cfg));
            chk($sformatf("tbl%0d_err", i), {31'd0, cfg_err_o}, {31'd0, tbl[i].err});
        end

        // Random data and sporadic config requests against the model.
        for (int it = 0; it < 300; it++) begin
            for (int m = 0; m < NM; m++) begin
                north_o_i[m*NW +: NW]  = NW'($urandom);
                north_oe_i[m*NW +: NW] = NW'($urandom);
                west_o_i[m*WW +: WW]   = WW'($urandom);
                west_oe_i[m*WW +: WW]  = WW'($urandom);
                east_o_i[m*EW +: EW]   = EW'($urandom);
                east_oe_i[m*EW +: EW]  = EW'($urandom);
            end
            cfg_valid_i = ($urandom_range(0, 3) == 0);
            cfg_i = (3*SW)'($urandom);
            cycle(hs);
        end
        cfg_valid_i = 1'b0;
        repeat (G + 3) cycle(hs);

        // Valid held through BLANK with a different cfg: ignored until ready returns.
        ca = {3'd4, 3'd3, 3'd2};
        cb = {3'd0, 3'd1, 3'd5};
        cfg_i = ca;
        cfg_valid_i = 1'b1;
        cycle(hs);
        cfg_i = cb;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) cycle(got);
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL hold_accept: second cfg not accepted within 20 cycles");
        end
        chk("hold_active_a", 32'(active_cfg_o), 32'(ca));
        cfg_valid_i = 1'b0;
        repeat (G + 2) cycle(hs);
        chk("hold_active_b", 32'(active_cfg_o), 32'(cb));

        // Reset in the middle of BLANK discards the pending cfg and the sticky error.
        cfg_i = {3'd1, 3'd1, 3'd1};
        cfg_valid_i = 1'b1;
        cycle(hs);
        cfg_valid_i = 1'b0;
        cycle(hs);
        cycle(hs);
        do_reset("rst_mid");
        repeat (G + 4) cycle(hs);
        chk("rst_mid_active_after", 32'(active_cfg_o), 32'd0);

`ifdef MPC_AUTO_SCAN_EN
        // Scan from all-zero: every edge advances by one per dwell period.
        do_reset("rst_scan");
        scan_en = 1'b1;
        prev = '0;
        for (int k = 1; k <= 4; k++) begin
            got = 1'b0;
            for (int c = 0; c < 60 && !got; c++) begin
                @(negedge clk);
                if (active_cfg_o !== prev) got = 1'b1;
            end
            if (!got) begin
                n_cmp++; n_bad++;
                $display("FAIL scan_step%0d: no config change within 60 cycles", k);
            end
            chk($sformatf("scan_step%0d", k), 32'(active_cfg_o), 32'(k * 73));
            prev = active_cfg_o;
        end
        scan_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
